// File: rtl/zxbus_master.sv
`default_nettype none
// ============================================================================
// Module   : zxbus_master
// Purpose  : ZX bus initiator running single Z80 memory/IO cycles through the
//            multiplexed FCO latch path. Optional: ZXB_WAIT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module zxbus_master #(
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        req_rnw,
  input  logic        req_mni,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        z_busrq,
  input  logic        z_busak,
  input  logic        z_wait,
  output logic        z_mrq,
  output logic        z_iorq,
  output logic        z_rd,
  output logic        z_wr,
  output logic [7:0]  fco_out,
  output logic [1:0]  fco_sel,
  output logic        fco_le,
  output logic        fco_oe,
  input  logic [7:0]  fci_in
`ifdef ZXB_WAIT_TIMEOUT_EN
  ,
  output logic        err
`endif
);

  localparam logic [7:0] c_SETUP_LAST  = 8'(T_SETUP - 1);
  localparam logic [7:0] c_STROBE_LAST = 8'(T_STROBE - 1);
  localparam logic [7:0] c_HOLD_LAST   = 8'(T_HOLD - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_BUSRQ  = 4'd1,
    S_LAT_AL = 4'd2,
    S_LAT_AH = 4'd3,
    S_LAT_D  = 4'd4,
    S_SETUP  = 4'd5,
    S_STROBE = 4'd6,
    S_HOLD   = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_rnw, r_mni;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_busak_meta, r_busak_sync;
  logic        r_wait_meta, r_wait_sync;
  logic        w_latch, w_capture, w_tmo_hit, w_tmo_end;
  logic [15:0] w_addr_cur;

  logic        w_ack_nxt, w_busrq_nxt, w_mrq_nxt, w_iorq_nxt, w_rd_nxt, w_wr_nxt;
  logic        w_le_nxt, w_oe_nxt;
  logic [7:0]  w_fco_out_nxt;
  logic [1:0]  w_fco_sel_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busak_meta <= 1'b0;
      r_busak_sync <= 1'b0;
      r_wait_meta  <= 1'b0;
      r_wait_sync  <= 1'b0;
    end else begin
      r_busak_meta <= z_busak;
      r_busak_sync <= r_busak_meta;
      r_wait_meta  <= z_wait;
      r_wait_sync  <= r_wait_meta;
    end
  end

`ifdef ZXB_WAIT_TIMEOUT_EN
  logic [7:0] r_wcnt;
  logic       r_tmo;

  // Counts only the WAIT-extension cycles past the programmed strobe width.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wcnt <= 8'd0;
      r_tmo  <= 1'b0;
    end else begin
      if (r_state != S_STROBE)
        r_wcnt <= 8'd0;
      else if (r_cnt == c_STROBE_LAST && r_wait_sync && !w_tmo_hit)
        r_wcnt <= r_wcnt + 8'd1;
      if (w_latch)
        r_tmo <= 1'b0;
      else if (w_tmo_end)
        r_tmo <= 1'b1;
    end
  end

  assign w_tmo_hit = (r_wcnt == 8'hFF);
`else
  assign w_tmo_hit = 1'b0;
`endif

  assign w_addr_cur = w_latch ? req_addr : r_addr;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    w_tmo_end   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_latch     = 1'b1;
          w_state_nxt = S_BUSRQ;
        end
      end
      S_BUSRQ:  if (r_busak_sync) w_state_nxt = S_LAT_AL;
      S_LAT_AL: w_state_nxt = S_LAT_AH;
      S_LAT_AH: begin
        w_state_nxt = r_rnw ? S_SETUP : S_LAT_D;
        w_cnt_nxt   = 8'd0;
      end
      S_LAT_D: begin
        w_state_nxt = S_SETUP;
        w_cnt_nxt   = 8'd0;
      end
      S_SETUP: begin
        if (r_cnt == c_SETUP_LAST) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_STROBE: begin
        // Counter parks at terminal count while WAIT stretches the strobe.
        if (r_cnt != c_STROBE_LAST) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end else if (!(r_wait_sync && !w_tmo_hit)) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = 8'd0;
          w_capture   = 1'b1;
          w_tmo_end   = r_wait_sync & w_tmo_hit;
        end
      end
      S_HOLD: begin
        if (r_cnt == c_HOLD_LAST) w_state_nxt = S_DONE;
        else                      w_cnt_nxt   = r_cnt + 8'd1;
      end
      S_DONE: begin
        if (req) begin
          w_latch     = 1'b1;
          w_state_nxt = S_LAT_AL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    w_ack_nxt     = (w_state_nxt == S_DONE);
    w_busrq_nxt   = (w_state_nxt != S_IDLE);
    w_mrq_nxt     = (w_state_nxt == S_STROBE) &&  r_mni;
    w_iorq_nxt    = (w_state_nxt == S_STROBE) && !r_mni;
    w_rd_nxt      = (w_state_nxt == S_STROBE) &&  r_rnw;
    w_wr_nxt      = (w_state_nxt == S_STROBE) && !r_rnw;
    w_oe_nxt      = !r_rnw && (w_state_nxt == S_LAT_D || w_state_nxt == S_SETUP ||
                               w_state_nxt == S_STROBE || w_state_nxt == S_HOLD);
    w_le_nxt      = 1'b0;
    w_fco_out_nxt = fco_out;
    w_fco_sel_nxt = fco_sel;
    case (w_state_nxt)
      S_LAT_AL: begin
        w_le_nxt      = 1'b1;
        w_fco_sel_nxt = 2'd0;
        w_fco_out_nxt = w_addr_cur[7:0];
      end
      S_LAT_AH: begin
        w_le_nxt      = 1'b1;
        w_fco_sel_nxt = 2'd1;
        w_fco_out_nxt = r_addr[15:8];
      end
      S_LAT_D: begin
        w_le_nxt      = 1'b1;
        w_fco_sel_nxt = 2'd2;
        w_fco_out_nxt = r_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_rnw   <= 1'b0;
      r_mni   <= 1'b0;
      r_addr  <= 16'd0;
      r_wdata <= 8'd0;
      ack     <= 1'b0;
      rdata   <= 8'd0;
      z_busrq <= 1'b0;
      z_mrq   <= 1'b0;
      z_iorq  <= 1'b0;
      z_rd    <= 1'b0;
      z_wr    <= 1'b0;
      fco_out <= 8'd0;
      fco_sel <= 2'd0;
      fco_le  <= 1'b0;
      fco_oe  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_rnw   <= req_rnw;
        r_mni   <= req_mni;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_capture && r_rnw)
        rdata <= w_tmo_end ? 8'hFF : fci_in;
      ack     <= w_ack_nxt;
      z_busrq <= w_busrq_nxt;
      z_mrq   <= w_mrq_nxt;
      z_iorq  <= w_iorq_nxt;
      z_rd    <= w_rd_nxt;
      z_wr    <= w_wr_nxt;
      fco_out <= w_fco_out_nxt;
      fco_sel <= w_fco_sel_nxt;
      fco_le  <= w_le_nxt;
      fco_oe  <= w_oe_nxt;
    end
  end

`ifdef ZXB_WAIT_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err <= 1'b0;
    else          err <= w_ack_nxt && r_tmo;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_zxbus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_zxbus_master
// Purpose  : Scoreboard bench for zxbus_master (honours ZXB_WAIT_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_zxbus_master;

  localparam int c_T_SETUP  = 2;
  localparam int c_T_STROBE = 4;
  localparam int c_T_HOLD   = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0, req_rnw = 1'b0, req_mni = 1'b0;
  logic [15:0] req_addr = 16'd0;
  logic [7:0]  req_wdata = 8'd0;
  logic        ack;
  logic [7:0]  rdata;
  logic        z_busrq;
  logic        z_busak = 1'b0, z_wait = 1'b0;
  logic        z_mrq, z_iorq, z_rd, z_wr;
  logic [7:0]  fco_out;
  logic [1:0]  fco_sel;
  logic        fco_le, fco_oe;
  logic [7:0]  fci_in = 8'd0;
`ifdef ZXB_WAIT_TIMEOUT_EN
  logic        err;
`endif

  zxbus_master #(
    .T_SETUP (c_T_SETUP),
    .T_STROBE(c_T_STROBE),
    .T_HOLD  (c_T_HOLD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_rnw  (req_rnw),
    .req_mni  (req_mni),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .ack      (ack),
    .rdata    (rdata),
    .z_busrq  (z_busrq),
    .z_busak  (z_busak),
    .z_wait   (z_wait),
    .z_mrq    (z_mrq),
    .z_iorq   (z_iorq),
    .z_rd     (z_rd),
    .z_wr     (z_wr),
    .fco_out  (fco_out),
    .fco_sel  (fco_sel),
    .fco_le   (fco_le),
    .fco_oe   (fco_oe),
    .fci_in   (fci_in)
`ifdef ZXB_WAIT_TIMEOUT_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rnw;
    bit          mni;
    logic [15:0] addr;
    logic [7:0]  data;
    int          sw;
    bit          er;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Host-side grant model: busak follows busrq after a programmable delay.
  int busak_delay = 3;
  bit busak_force = 1'b0;
  int gcnt = 0;
  always @(posedge clk) begin
    #1;
    if (!z_busrq) begin
      gcnt    = 0;
      z_busak = busak_force;
    end else if (gcnt >= busak_delay) begin
      z_busak = 1'b1;
    end else begin
      gcnt++;
    end
  end

  // Bus monitor: external latches, strobe shape, grant count, ack scoreboard.
  logic [7:0] lat [3];
  int         sw = 0, last_sw = 0, overlap = 0, rises = 0, acks = 0;
  bit         in_s = 1'b0, prev_busrq = 1'b0, s_oe = 1'b0;
  logic [3:0] s_flags = 4'd0;
  always @(negedge clk) begin
    if (fco_le && fco_sel != 2'd3) lat[fco_sel] = fco_out;
    if (z_rd && z_wr) overlap++;
    if (z_rd || z_wr) begin
      if (!in_s) sw = 0;
      in_s    = 1'b1;
      sw++;
      s_flags = {z_mrq, z_iorq, z_rd, z_wr};
      s_oe    = fco_oe;
    end else begin
      if (in_s) last_sw = sw;
      in_s = 1'b0;
    end
    if (z_busrq && !prev_busrq) rises++;
    prev_busrq = z_busrq;
    if (ack) begin
      acks++;
      if (sb.size() == 0) begin
        check("sb_unexpected_ack", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("addr_lo_latch", lat[0], e.addr[7:0]);
        check("addr_hi_latch", lat[1], e.addr[15:8]);
        if (e.rnw) check("rdata", rdata, e.data);
        else       check("zd_latch", lat[2], e.data);
        check("strobe_kind", s_flags, {e.mni, !e.mni, e.rnw, !e.rnw});
        check("strobe_width", last_sw, e.sw);
        check("fco_oe_in_strobe", s_oe, !e.rnw);
`ifdef ZXB_WAIT_TIMEOUT_EN
        check("err", err, e.er);
`endif
      end
    end
  end

  task automatic push_exp(input bit rnw, input bit mni, input logic [15:0] addr,
                          input logic [7:0] d, input int w, input bit er);
    exp_t e;
    e.rnw = rnw; e.mni = mni; e.addr = addr; e.data = d; e.sw = w; e.er = er;
    sb.push_back(e);
  endtask

  task automatic do_txn(input bit rnw, input bit mni, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [7:0] expd, input int w,
                        input bit er, output int cyc);
    bit got;
    push_exp(rnw, mni, addr, rnw ? expd : wd, w, er);
    @(posedge clk); #1;
    req = 1'b1; req_rnw = rnw; req_mni = mni; req_addr = addr; req_wdata = wd;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 2000) begin
      @(posedge clk); #1;
      req = 1'b0;
      cyc++;
      if (ack) got = 1'b1;
    end
    if (!got) check("ack_timeout", 0, 1);
  endtask

  int          lat_cyc, k, n, rises0, acks0;
  logic [15:0] b_addr [3];
  logic [7:0]  b_data [3];

  initial begin
    b_addr[0] = 16'h8000; b_addr[1] = 16'h8001; b_addr[2] = 16'h80FF;
    b_data[0] = 8'h11;    b_data[1] = 8'h22;    b_data[2] = 8'h33;

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {ack, z_busrq, z_mrq, z_iorq, z_rd, z_wr, fco_le, fco_oe}, 8'h00);
    check("rst_rdata", rdata, 8'h00);
    check("rst_fco", {fco_out, fco_sel}, 10'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busrq", z_busrq, 0);

    // Memory read, grant after 3 cycles.
    busak_delay = 3;
    fci_in = 8'hA5;
    do_txn(1'b1, 1'b1, 16'h5B12, 8'h00, 8'hA5, c_T_STROBE, 1'b0, lat_cyc);

    // IO write with grant already present: fixed latency, busrq drops after DONE.
    busak_force = 1'b1;
    repeat (4) @(posedge clk);
    do_txn(1'b0, 1'b0, 16'h00FE, 8'h07, 8'h00, c_T_STROBE, 1'b0, lat_cyc);
    check("write_latency", lat_cyc, 2 + 1 + 1 + 1 + c_T_SETUP + c_T_STROBE + c_T_HOLD);
    check("busrq_in_done", z_busrq, 1);
    @(posedge clk); #1;
    check("busrq_after_done", z_busrq, 0);
    busak_force = 1'b0;
    repeat (3) @(posedge clk);

    // WAIT held 10 cycles from strobe start; one cycle is absorbed by the
    // synchroniser, and data is sampled only after release.
    fci_in = 8'h3C;
    fork
      do_txn(1'b1, 1'b1, 16'hC0DE, 8'h00, 8'hC3, c_T_STROBE + 10 - 1, 1'b0, lat_cyc);
      begin
        k = 0;
        while (!z_rd && k < 200) begin @(negedge clk); k++; end
        z_wait = 1'b1;
        repeat (10) @(negedge clk);
        z_wait = 1'b0;
        fci_in = 8'hC3;
      end
    join
    repeat (3) @(posedge clk);

    // Burst of three writes with req held high.
    busak_delay = 2;
    rises0 = rises;
    for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b1, b_addr[i], b_data[i], c_T_STROBE, 1'b0);
    @(posedge clk); #1;
    req = 1'b1; req_rnw = 1'b0; req_mni = 1'b1; req_addr = b_addr[0]; req_wdata = b_data[0];
    n = 0;
    k = 0;
    while (n < 3 && k < 500) begin
      @(posedge clk); #1;
      k++;
      if (ack) begin
        n++;
        if (n < 3) begin
          req_addr = b_addr[n];
          req_wdata = b_data[n];
        end else begin
          req = 1'b0;
        end
      end
    end
    req = 1'b0;
    check("burst_acks", n, 3);
    repeat (3) @(posedge clk);
    check("burst_single_grant", rises - rises0, 1);

    // Asynchronous reset in the middle of a write strobe.
    acks0 = acks;
    fork
      begin
        @(posedge clk); #1;
        req = 1'b1; req_rnw = 1'b0; req_mni = 1'b0; req_addr = 16'h1234; req_wdata = 8'h55;
        @(posedge clk); #1;
        req = 1'b0;
      end
      begin
        k = 0;
        while (!z_wr && k < 200) begin @(negedge clk); k++; end
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_strobes", {z_mrq, z_iorq, z_rd, z_wr}, 4'h0);
        check("abort_busrq_oe", {z_busrq, fco_oe}, 2'b00);
      end
    join
    repeat (3) @(posedge clk);
    check("abort_no_ack", acks - acks0, 0);
    #1;
    reset_n = 1'b1;
    fci_in = 8'h99;
    do_txn(1'b1, 1'b1, 16'h4000, 8'h00, 8'h99, c_T_STROBE, 1'b0, lat_cyc);

`ifdef ZXB_WAIT_TIMEOUT_EN
    // WAIT stuck high: terminates after 255 extension cycles with err.
    repeat (2) @(posedge clk);
    z_wait = 1'b1;
    fci_in = 8'h5A;
    do_txn(1'b1, 1'b1, 16'h1111, 8'h00, 8'hFF, c_T_STROBE + 255, 1'b1, lat_cyc);
    z_wait = 1'b0;
`endif

    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    check("rd_wr_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
